// File: rtl/user_axi_pkg.sv
// Shared constants, state types and request classification for the
// user-partition AXI DMA scratch RAM.
package user_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Only full 16-byte beats are supported.
    localparam logic [2:0] SIZE_16B = 3'd4;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Decode error beats slave error; a request that decodes but uses an
    // unsupported size or a WRAP/reserved burst type is a slave error.
    function automatic logic [1:0] classify_req(
        input logic       out_of_range,
        input logic [2:0] size,
        input logic [1:0] burst
    );
        if (out_of_range)
            return RESP_DECERR;
        else if (size != SIZE_16B || (burst != BURST_FIXED && burst != BURST_INCR))
            return RESP_SLVERR;
        else
            return RESP_OKAY;
    endfunction

endpackage

// File: rtl/user_bram_sdp.sv
// Simple dual-port block RAM: one byte-enabled write port and one registered
// read port with enable. A read of a word written on the same edge returns
// the old contents (read-first). Contents have no reset.
module user_bram_sdp #(
    parameter int WIDTH      = 128,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [DEPTH_LOG2-1:0]   wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [WIDTH/8-1:0]      wr_be,
    input  logic                    rd_en,
    input  logic [DEPTH_LOG2-1:0]   rd_addr,
    output logic [WIDTH-1:0]        rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Byte-masked write and registered read share one edge, giving read-first.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < WIDTH/8; i++) begin
                if (wr_be[i])
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/user_axi_dma_ram.sv
// AXI4 responder terminating the shell's 128-bit DMA master with on-chip RAM.
// Independent read and write engines, one burst outstanding per direction.
module user_axi_dma_ram
    import user_axi_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 128,
    parameter int MEM_WORDS_LOG2 = 10
) (
    input  logic                  shell_axi_clk,
    input  logic                  shell_rst,

    input  logic [ADDR_W-1:0]     shell_axi_dma_awaddr,
    input  logic [1:0]            shell_axi_dma_awburst,
    input  logic [3:0]            shell_axi_dma_awcache,
    input  logic [7:0]            shell_axi_dma_awlen,
    input  logic                  shell_axi_dma_awlock,
    input  logic [2:0]            shell_axi_dma_awprot,
    input  logic [3:0]            shell_axi_dma_awqos,
    input  logic [2:0]            shell_axi_dma_awsize,
    input  logic                  shell_axi_dma_awvalid,
    output logic                  shell_axi_dma_awready,

    input  logic [DATA_W-1:0]     shell_axi_dma_wdata,
    input  logic [DATA_W/8-1:0]   shell_axi_dma_wstrb,
    input  logic                  shell_axi_dma_wlast,
    input  logic                  shell_axi_dma_wvalid,
    output logic                  shell_axi_dma_wready,

    output logic [1:0]            shell_axi_dma_bresp,
    output logic                  shell_axi_dma_bvalid,
    input  logic                  shell_axi_dma_bready,

    input  logic [ADDR_W-1:0]     shell_axi_dma_araddr,
    input  logic [1:0]            shell_axi_dma_arburst,
    input  logic [3:0]            shell_axi_dma_arcache,
    input  logic [7:0]            shell_axi_dma_arlen,
    input  logic                  shell_axi_dma_arlock,
    input  logic [2:0]            shell_axi_dma_arprot,
    input  logic [3:0]            shell_axi_dma_arqos,
    input  logic [2:0]            shell_axi_dma_arsize,
    input  logic                  shell_axi_dma_arvalid,
    output logic                  shell_axi_dma_arready,

    output logic [DATA_W-1:0]     shell_axi_dma_rdata,
    output logic [1:0]            shell_axi_dma_rresp,
    output logic                  shell_axi_dma_rlast,
    output logic                  shell_axi_dma_rvalid,
    input  logic                  shell_axi_dma_rready
);

    localparam int IDX_W   = MEM_WORDS_LOG2;
    localparam int IDX_LSB = 4;
    localparam logic [IDX_W-1:0] IDX_ONE = 1;

    // Ignored request attributes and the byte offset within a word.
    logic unused_inputs;
    assign unused_inputs = ^{shell_axi_dma_awcache, shell_axi_dma_awlock, shell_axi_dma_awprot,
                             shell_axi_dma_awqos, shell_axi_dma_awaddr[IDX_LSB-1:0],
                             shell_axi_dma_arcache, shell_axi_dma_arlock, shell_axi_dma_arprot,
                             shell_axi_dma_arqos, shell_axi_dma_araddr[IDX_LSB-1:0]};

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = shell_axi_dma_awvalid & shell_axi_dma_awready;
    assign w_hs  = shell_axi_dma_wvalid  & shell_axi_dma_wready;
    assign b_hs  = shell_axi_dma_bvalid  & shell_axi_dma_bready;
    assign ar_hs = shell_axi_dma_arvalid & shell_axi_dma_arready;
    assign r_hs  = shell_axi_dma_rvalid  & shell_axi_dma_rready;

    logic [1:0] aw_resp, ar_resp;
    assign aw_resp = classify_req(|shell_axi_dma_awaddr[ADDR_W-1:IDX_LSB+IDX_W],
                                  shell_axi_dma_awsize, shell_axi_dma_awburst);
    assign ar_resp = classify_req(|shell_axi_dma_araddr[ADDR_W-1:IDX_LSB+IDX_W],
                                  shell_axi_dma_arsize, shell_axi_dma_arburst);

    // ---------------- write engine ----------------
    wr_state_t        wr_state;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       wr_len;
    logic [7:0]       wr_cnt;
    logic             wr_incr;
    logic             wr_ok;
    logic             w_final;

    assign w_final = (wr_cnt == wr_len);

    // Write FSM: accept AW, count beats to len (wlast only checked), respond.
    always_ff @(posedge shell_axi_clk) begin
        if (shell_rst) begin
            wr_state              <= W_IDLE;
            wr_idx                <= '0;
            wr_len                <= '0;
            wr_cnt                <= '0;
            wr_incr               <= 1'b0;
            wr_ok                 <= 1'b0;
            shell_axi_dma_awready <= 1'b0;
            shell_axi_dma_wready  <= 1'b0;
            shell_axi_dma_bvalid  <= 1'b0;
            shell_axi_dma_bresp   <= RESP_OKAY;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    shell_axi_dma_awready <= 1'b1;
                    if (aw_hs) begin
                        shell_axi_dma_awready <= 1'b0;
                        shell_axi_dma_wready  <= 1'b1;
                        wr_idx                <= shell_axi_dma_awaddr[IDX_LSB +: IDX_W];
                        wr_len                <= shell_axi_dma_awlen;
                        wr_cnt                <= '0;
                        wr_incr               <= (shell_axi_dma_awburst == BURST_INCR);
                        wr_ok                 <= (aw_resp == RESP_OKAY);
                        shell_axi_dma_bresp   <= aw_resp;
                        wr_state              <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (wr_incr)
                            wr_idx <= wr_idx + IDX_ONE;
                        wr_cnt <= wr_cnt + 8'd1;
                        if ((shell_axi_dma_wlast != w_final) && (shell_axi_dma_bresp != RESP_DECERR))
                            shell_axi_dma_bresp <= RESP_SLVERR;
                        if (w_final) begin
                            shell_axi_dma_wready <= 1'b0;
                            shell_axi_dma_bvalid <= 1'b1;
                            wr_state             <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        shell_axi_dma_bvalid  <= 1'b0;
                        shell_axi_dma_awready <= 1'b1;
                        wr_state              <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read engine ----------------
    rd_state_t        rd_state;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] rd_next;
    logic [7:0]       rd_len;
    logic [7:0]       rd_cnt;
    logic             rd_incr;
    logic [1:0]       rresp_q;
    logic             ram_re;
    logic [IDX_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_q;

    assign rd_next   = rd_incr ? (rd_idx + IDX_ONE) : rd_idx;
    // The RAM output register doubles as the R-channel data holding register.
    assign ram_re    = ~shell_axi_dma_rvalid | shell_axi_dma_rready;
    assign ram_raddr = (rd_state == R_IDLE) ? shell_axi_dma_araddr[IDX_LSB +: IDX_W] : rd_next;

    assign shell_axi_dma_rresp = rresp_q;
    assign shell_axi_dma_rdata = (shell_axi_dma_rvalid && rresp_q == RESP_OKAY) ? ram_q : '0;

    // Read FSM: accept AR, stream len+1 beats with one-cycle RAM latency.
    always_ff @(posedge shell_axi_clk) begin
        if (shell_rst) begin
            rd_state              <= R_IDLE;
            rd_idx                <= '0;
            rd_len                <= '0;
            rd_cnt                <= '0;
            rd_incr               <= 1'b0;
            rresp_q               <= RESP_OKAY;
            shell_axi_dma_arready <= 1'b0;
            shell_axi_dma_rvalid  <= 1'b0;
            shell_axi_dma_rlast   <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    shell_axi_dma_arready <= 1'b1;
                    if (ar_hs) begin
                        shell_axi_dma_arready <= 1'b0;
                        shell_axi_dma_rvalid  <= 1'b1;
                        shell_axi_dma_rlast   <= (shell_axi_dma_arlen == 8'd0);
                        rd_idx                <= shell_axi_dma_araddr[IDX_LSB +: IDX_W];
                        rd_len                <= shell_axi_dma_arlen;
                        rd_cnt                <= '0;
                        rd_incr               <= (shell_axi_dma_arburst == BURST_INCR);
                        rresp_q               <= ar_resp;
                        rd_state              <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (shell_axi_dma_rlast) begin
                            shell_axi_dma_rvalid  <= 1'b0;
                            shell_axi_dma_rlast   <= 1'b0;
                            shell_axi_dma_arready <= 1'b1;
                            rresp_q               <= RESP_OKAY;
                            rd_state              <= R_IDLE;
                        end else begin
                            rd_idx              <= rd_next;
                            rd_cnt              <= rd_cnt + 8'd1;
                            shell_axi_dma_rlast <= ((rd_cnt + 8'd1) == rd_len);
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    user_bram_sdp #(
        .WIDTH      (DATA_W),
        .DEPTH_LOG2 (IDX_W)
    ) u_ram (
        .clk     (shell_axi_clk),
        .wr_en   (w_hs & wr_ok),
        .wr_addr (wr_idx),
        .wr_data (shell_axi_dma_wdata),
        .wr_be   (shell_axi_dma_wstrb),
        .rd_en   (ram_re),
        .rd_addr (ram_raddr),
        .rd_data (ram_q)
    );

endmodule

// File: doc/user_axi_dma_ram.md
Name: user_axi_dma_ram

Overview:
- User-partition AXI4 responder (slave) that terminates the shell's 128-bit AXI DMA master interface (the `shell_axi_dma_*` signals) with on-chip block RAM.
- Gives host DMA a scratch memory. It is the first non-trivial consumer of the DMA port in the user partition.
- Read and write channels run independently, with one burst outstanding per direction.

Parameters:
ADDR_W, 64, AXI address width
DATA_W, 128, AXI data width (fixed; STRB_W = DATA_W/8)
MEM_WORDS_LOG2, 10, log2 of RAM depth in DATA_W words (default 16 KiB)

Ports:
shell_axi_clk  in  1  sole clock
shell_rst  in  1  reset, synchronous, active-high
shell_axi_dma_aw{addr,burst,cache,len,lock,prot,qos,size,valid}  in  64/2/4/8/1/3/4/3/1  write address; cache/lock/prot/qos ignored
shell_axi_dma_awready  out  1  write address ready
shell_axi_dma_w{data,strb,last,valid}  in  128/16/1/1  write data
shell_axi_dma_wready  out  1  write data ready
shell_axi_dma_b{resp,valid}  out  2/1  write response
shell_axi_dma_bready  in  1  response ready
shell_axi_dma_ar{addr,burst,cache,len,lock,prot,qos,size,valid}  in  64/2/4/8/1/3/4/3/1  read address; cache/lock/prot/qos ignored
shell_axi_dma_arready  out  1  read address ready
shell_axi_dma_r{data,resp,last,valid}  out  128/2/1/1  read data
shell_axi_dma_rready  in  1  read data ready

Behaviour:
- Reset: clock is `shell_axi_clk`; reset is synchronous and active-high on `shell_rst`.
  - While `shell_rst`=1, all outputs are 0. Both FSMs go to IDLE and any burst in progress is abandoned.
  - RAM contents are preserved.
  - `awready`/`arready` rise the first cycle after reset deasserts.
- Word index: addr[4 +: MEM_WORDS_LOG2]. addr[3:0] is ignored (aligned transfers only).
- Error classification, latched at address handshake:
  - addr[ADDR_W-1 : 4+MEM_WORDS_LOG2] != 0 → DECERR (2'b11).
  - Otherwise size != 3'd4, or burst not FIXED/INCR → SLVERR (2'b10).
  - Otherwise OKAY.
  - Errored write bursts perform no RAM writes. Errored read bursts return all-zero data.
- Burst addressing:
  - INCR: word index += 1 per beat, wrapping modulo 2^MEM_WORDS_LOG2.
  - FIXED: index is constant.
  - Beats = len+1 (1..256).
- Write FSM:
  - W_IDLE: awready=1. On awvalid, latch the request and go to W_DATA.
  - W_DATA: wready=1. Each wvalid beat writes the RAM with byte enables = wstrb (if OKAY).
  - Beat counter: on the beat where count==len, go to W_RESP regardless of wlast.
  - Protocol check: if wlast != (count==len) on any beat, bresp becomes SLVERR unless it is already DECERR. Writes still occur.
  - W_RESP: bvalid=1 and bresp held stable until bready, then W_IDLE.
  - No AW is accepted before B completes. Minimum turnaround is 1 idle cycle.
- Read FSM:
  - R_IDLE: arready=1. On arvalid, latch the request, issue a RAM read of the first word, go to R_DATA.
  - R_DATA: rvalid=1 from the cycle after the AR handshake (latency 1).
  - RAM read enable = !rvalid | rready. rdata/rresp/rlast hold stable while rvalid & !rready.
  - On rvalid&rready with !rlast, the next word is read at the same edge, so back-to-back beats run at full throughput.
  - rlast=1 on beat len. A handshake on the last beat drops rvalid and returns to R_IDLE.
- Same-cycle read and write to the same word: read returns old data (read-first).
- AW and AR handshakes in the same cycle are both accepted; the channels are independent.

Decomposition:
- Package `user_axi_pkg`:
  - BURST_FIXED/INCR/WRAP constants
  - RESP_OKAY/SLVERR/DECERR constants
  - wr_state_t {W_IDLE, W_DATA, W_RESP}
  - rd_state_t {R_IDLE, R_DATA}
- Sub-module `user_bram_sdp`:
  - simple dual-port, read-first
  - one write port with per-byte enables
  - one synchronous read port with enable
  - parameterised on width and depth

Test Plan:
1. INCR write: addr 0x100, len 3, data 0xA0..A3, strb all ones, then INCR read of the same → rdata A0..A3 on consecutive cycles with rready=1, rlast on beat 3, OKAY, bresp OKAY.
2. Partial strobe: write 0xFF..FF to word 0, then write 0 with strb 16'h00F0, then read → bytes 4–7 are zero, all others 0xFF.
3. rready toggling 1/0 on a len=7 read → no beat lost or duplicated; rdata stable while stalled; 8 handshakes total.
4. Out-of-range address 0x1_0000_0000 write and read with len 1 → bresp DECERR, rdata 0 with rresp DECERR on 2 beats, RAM unchanged.
5. Early wlast on beat 1 of len=2 → FSM reaches W_RESP only after beat 2, bresp SLVERR. Separately, size=2 → SLVERR with no write.
6. Reset asserted mid-read burst (beat 3 of 8) → next cycle rvalid=0, arready=1 after deassert, and a new read returns the pre-reset RAM contents.
